// File: rtl/pot_sweep_sched.sv
// Round-robin A2D sequencer for the six equalizer/volume slide pots.
// Issues one conversion per slot, captures results, and times out stalled slots.
module pot_sweep_sched #(
    parameter int unsigned SWEEP_GAP = 1024,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        strt_cnv_o,
    output logic [2:0]  chnnl_o,
    input  logic        cnv_cmplt_i,
    input  logic [11:0] res_i,
    input  logic        sweep_now_i,
    input  logic        clr_err_i,
    output logic [11:0] pot_lp_o,
    output logic [11:0] pot_b1_o,
    output logic [11:0] pot_b2_o,
    output logic [11:0] pot_b3_o,
    output logic [11:0] pot_hp_o,
    output logic [11:0] volume_o,
    output logic        sweep_done_o,
    output logic        timeout_err_o
);

    localparam int unsigned RES_W     = 12;
    localparam int unsigned CH_W      = 3;
    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned NUM_POTS  = 6;
    localparam int unsigned LAST_SLOT = NUM_POTS - 1;
    localparam int unsigned GAP_W     = $clog2(SWEEP_GAP + 1);
    localparam int unsigned WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [RES_W-1:0] POT_RST = RES_W'(12'h800);
    localparam logic [CH_W-1:0]  CH_RST  = CH_W'(1);

    typedef enum logic [1:0] {
        ST_GAP  = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_NEXT = 2'd3
    } state_e;

    state_e              state_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [SLOT_W-1:0]   slot_q;
    logic                pending_q;
    logic                strt_cnv_q;
    logic [CH_W-1:0]     chnnl_q;
    logic                sweep_done_q;
    logic                timeout_err_q;
    logic [RES_W-1:0]    pot_q [NUM_POTS];

    logic                gap_done;
    logic                wait_expired;
    logic                slot_last;
    logic [SLOT_W-1:0]   slot_inc;

    // Fixed sweep order: LP, B1, B2, B3, HP, VOLUME on the A2D mux channels.
    function automatic logic [CH_W-1:0] slot_chnnl(input logic [SLOT_W-1:0] slot);
        logic [CH_W-1:0] ch;
        case (slot)
            SLOT_W'(0): ch = CH_W'(1);
            SLOT_W'(1): ch = CH_W'(0);
            SLOT_W'(2): ch = CH_W'(4);
            SLOT_W'(3): ch = CH_W'(2);
            SLOT_W'(4): ch = CH_W'(3);
            default:    ch = CH_W'(7);
        endcase
        return ch;
    endfunction

    assign gap_done     = (gap_cnt_q == GAP_W'(SWEEP_GAP));
    assign wait_expired = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
    assign slot_last    = (slot_q == SLOT_W'(LAST_SLOT));
    assign slot_inc     = slot_q + SLOT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_GAP;
            gap_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            slot_q        <= '0;
            pending_q     <= 1'b0;
            strt_cnv_q    <= 1'b0;
            chnnl_q       <= CH_RST;
            sweep_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < int'(NUM_POTS); i++) begin
                pot_q[i] <= POT_RST;
            end
        end else begin
            strt_cnv_q   <= 1'b0;
            sweep_done_q <= 1'b0;
            if (sweep_now_i) begin
                pending_q <= 1'b1;
            end
            // A timeout later in this block overrides a same-cycle clear.
            if (clr_err_i) begin
                timeout_err_q <= 1'b0;
            end

            case (state_q)
                ST_GAP: begin
                    if (pending_q || gap_done) begin
                        state_q    <= ST_REQ;
                        slot_q     <= '0;
                        pending_q  <= 1'b0;
                        strt_cnv_q <= 1'b1;
                        chnnl_q    <= slot_chnnl(SLOT_W'(0));
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end

                ST_REQ: begin
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (cnv_cmplt_i) begin
                        for (int i = 0; i < int'(NUM_POTS); i++) begin
                            if (slot_q == SLOT_W'(i)) begin
                                pot_q[i] <= res_i;
                            end
                        end
                        state_q <= ST_NEXT;
                    end else if (wait_expired) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_NEXT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end

                ST_NEXT: begin
                    if (!slot_last) begin
                        slot_q     <= slot_inc;
                        state_q    <= ST_REQ;
                        strt_cnv_q <= 1'b1;
                        chnnl_q    <= slot_chnnl(slot_inc);
                    end else begin
                        sweep_done_q <= 1'b1;
                        gap_cnt_q    <= '0;
                        state_q      <= ST_GAP;
                    end
                end

                default: begin
                    state_q <= ST_GAP;
                end
            endcase
        end
    end

    assign strt_cnv_o    = strt_cnv_q;
    assign chnnl_o       = chnnl_q;
    assign sweep_done_o  = sweep_done_q;
    assign timeout_err_o = timeout_err_q;
    assign pot_lp_o      = pot_q[0];
    assign pot_b1_o      = pot_q[1];
    assign pot_b2_o      = pot_q[2];
    assign pot_b3_o      = pot_q[3];
    assign pot_hp_o      = pot_q[4];
    assign volume_o      = pot_q[5];

endmodule
